// File: rtl/ssp_rx_deserializer_if.sv
// Receive-FIFO write port of the SSP receive deserializer: write strobe, word, overrun pulse, full flag.
interface ssp_rx_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_wr_en;
  logic [DATA_WIDTH-1:0] rx_wr_data;
  logic                  rx_overrun;
  logic                  rxfifo_full;

  modport master (
    output rx_wr_en,
    output rx_wr_data,
    output rx_overrun,
    input  rxfifo_full
  );

  modport slave (
    input  rx_wr_en,
    input  rx_wr_data,
    input  rx_overrun,
    output rxfifo_full
  );
endinterface

// File: rtl/ssp_rx_deserializer.sv
// SSP receive serial-to-parallel: samples ssprxd on sspclkin falls (pclk domain), MSB first; write/overrun 1 pclk after last bit (+2 with SSP_RX_SYNC_EN).
// No backpressure: a word completing while rxfifo_full is high is dropped and flagged on rx_overrun.
module ssp_rx_deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         pclk,
  input  logic                         clear_b,
  input  logic                         sspclkin,
  input  logic                         sspfssin,
  input  logic                         ssprxd,
  output logic                         rx_busy,
  ssp_rx_deserializer_if.master        fifo
);

  localparam int            CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic sclk_in;
  logic fss_in;
  logic rxd_in;

`ifdef SSP_RX_SYNC_EN
  logic [1:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] fss_sync_q,  fss_sync_d;
  logic [1:0] rxd_sync_q,  rxd_sync_d;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], sspclkin};
    fss_sync_d  = {fss_sync_q[0],  sspfssin};
    rxd_sync_d  = {rxd_sync_q[0],  ssprxd};
  end

  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      sclk_sync_q <= 2'b00;
      fss_sync_q  <= 2'b00;
      rxd_sync_q  <= 2'b00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      fss_sync_q  <= fss_sync_d;
      rxd_sync_q  <= rxd_sync_d;
    end
  end

  assign sclk_in = sclk_sync_q[1];
  assign fss_in  = fss_sync_q[1];
  assign rxd_in  = rxd_sync_q[1];
`else
  assign sclk_in = sspclkin;
  assign fss_in  = sspfssin;
  assign rxd_in  = ssprxd;
`endif

  state_t                state_q,   state_d;
  logic [CW-1:0]         count_q,   count_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  sclk_q,    sclk_d;
  logic                  wr_en_q,   wr_en_d;
  logic                  overrun_q, overrun_d;
  logic                  fall;
  logic [DATA_WIDTH-1:0] word;

  assign sclk_d = sclk_in;
  assign fall   = sclk_q & ~sclk_in;
  // Word as it stands once the current bit is shifted in; only meaningful on a fall.
  assign word   = {shift_q[DATA_WIDTH-2:0], rxd_in};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && fss_in) begin
          state_d = SHIFT;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          shift_d = word;
          if (count_q == LAST) begin
            count_d = '0;
            // Frame sync on the last bit chains straight into the next frame.
            state_d = fss_in ? SHIFT : IDLE;
            if (fifo.rxfifo_full) begin
              overrun_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_data_d = word;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      wr_data_q <= '0;
      sclk_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      wr_data_q <= wr_data_d;
      sclk_q    <= sclk_d;
      wr_en_q   <= wr_en_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_busy         = (state_q == SHIFT);
  assign fifo.rx_wr_en   = wr_en_q;
  assign fifo.rx_wr_data = wr_data_q;
  assign fifo.rx_overrun = overrun_q;

endmodule

// File: tb/tb_ssp_rx_deserializer.sv
// Directed bench for ssp_rx_deserializer: table of single frames plus reset, back-to-back and mid-frame reset sequences.
module tb_ssp_rx_deserializer;

  localparam int W = 8;
`ifdef SSP_RX_SYNC_EN
  localparam int HALF = 2;
  localparam int XLAT = 2;
`else
  localparam int HALF = 1;
  localparam int XLAT = 0;
`endif

  logic pclk     = 1'b0;
  logic clear_b  = 1'b0;
  logic sspclkin = 1'b0;
  logic sspfssin = 1'b0;
  logic ssprxd   = 1'b0;
  logic rx_busy;

  ssp_rx_deserializer_if #(.DATA_WIDTH(W)) rx_if ();

  ssp_rx_deserializer #(.DATA_WIDTH(W)) dut (
    .pclk     (pclk),
    .clear_b  (clear_b),
    .sspclkin (sspclkin),
    .sspfssin (sspfssin),
    .ssprxd   (ssprxd),
    .rx_busy  (rx_busy),
    .fifo     (rx_if)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  int          wr_cnt    = 0;
  int          ovr_cnt   = 0;
  int          both_cnt  = 0;
  int          busy_last = -1;
  int          wr_cyc[$];
  logic [7:0]  wr_dat[$];

  always @(negedge pclk) begin
    if (rx_if.rx_wr_en) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      wr_dat.push_back(rx_if.rx_wr_data);
    end
    if (rx_if.rx_overrun) ovr_cnt++;
    if (rx_if.rx_wr_en && rx_if.rx_overrun) both_cnt++;
    if (rx_busy) busy_last = cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int last_fall = 0;

  // One serial bit: high phase then low phase; the fall is sampled on the first pclk edge of the low phase.
  task automatic sbit(input logic fss, input logic d);
    sspclkin = 1'b1;
    sspfssin = fss;
    ssprxd   = d;
    repeat (HALF) @(negedge pclk);
    sspclkin  = 1'b0;
    last_fall = cyc + 1;
    repeat (HALF) @(negedge pclk);
  endtask

  task automatic send_frame(input logic [7:0] w, input int noise, input logic b2b, input logic lead);
    if (lead) sbit(1'b1, 1'b0);
    for (int i = 0; i < W; i++)
      sbit((i == noise) || ((i == W - 1) && b2b), w[W-1-i]);
    sspfssin = 1'b0;
  endtask

  task automatic wait_to(input int target);
    int guard = 0;
    while (cyc < target && guard < 100) begin
      @(negedge pclk);
      guard++;
    end
  endtask

  typedef struct {
    logic [7:0] word;
    logic       full;
    int         noise;
    int         exp_wr;
    int         exp_ovr;
    logic [7:0] exp_dat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int         wr0, ovr0, n0, lf1, lf2;
    logic [3:0] acc;

    tbl[0] = '{8'hA5, 1'b0, -1, 1, 0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b1, -1, 0, 1, 8'hA5};
    tbl[2] = '{8'hC3, 1'b0, -1, 1, 0, 8'hC3};
    tbl[3] = '{8'h55, 1'b0,  3, 1, 0, 8'h55};
    tbl[4] = '{8'h00, 1'b0, -1, 1, 0, 8'h00};
    tbl[5] = '{8'hFF, 1'b1, -1, 0, 1, 8'h00};
    tbl[6] = '{8'h80, 1'b0,  0, 1, 0, 8'h80};
    tbl[7] = '{8'h01, 1'b0,  6, 1, 0, 8'h01};

    rx_if.rxfifo_full = 1'b0;

    // Reset held with all inputs toggling: every output stays at zero.
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge pclk);
      sspclkin = i[0];
      sspfssin = i[1];
      ssprxd   = i[2];
      acc = acc | {rx_if.rx_wr_en, rx_if.rx_overrun, rx_busy, |rx_if.rx_wr_data};
    end
    chk("reset_outputs", 32'(acc), 32'd0);
    chk("reset_wr_data", 32'(rx_if.rx_wr_data), 32'd0);
    @(negedge pclk);
    sspclkin = 1'b0;
    sspfssin = 1'b0;
    clear_b  = 1'b1;
    @(negedge pclk);

    // Data toggling with no frame sync: nothing is written.
    for (int i = 0; i < 12; i++) sbit(1'b0, i[0]);
    repeat (4 + XLAT) @(negedge pclk);
    chk("nofss_wr", 32'(wr_cnt), 32'd0);
    chk("nofss_ovr", 32'(ovr_cnt), 32'd0);
    chk("nofss_busy", 32'(busy_last), 32'hFFFF_FFFF);

    for (int r = 0; r < 8; r++) begin
      wr0  = wr_cnt;
      ovr0 = ovr_cnt;
      rx_if.rxfifo_full = tbl[r].full;
      send_frame(tbl[r].word, tbl[r].noise, 1'b0, 1'b1);
      wait_to(last_fall + XLAT);
      chk($sformatf("row%0d_busy_drop", r), 32'(rx_busy), 32'd0);
      chk($sformatf("row%0d_busy_last", r), 32'(busy_last), 32'(last_fall + XLAT - 1));
      repeat (3) @(negedge pclk);
      rx_if.rxfifo_full = 1'b0;
      chk($sformatf("row%0d_wr", r), 32'(wr_cnt - wr0), 32'(tbl[r].exp_wr));
      chk($sformatf("row%0d_ovr", r), 32'(ovr_cnt - ovr0), 32'(tbl[r].exp_ovr));
      chk($sformatf("row%0d_data", r), 32'(rx_if.rx_wr_data), 32'(tbl[r].exp_dat));
      if (tbl[r].exp_wr == 1 && wr_cnt > wr0)
        chk($sformatf("row%0d_strobe_cyc", r), 32'(wr_cyc[wr_cyc.size()-1]), 32'(last_fall + XLAT));
    end

    // Back-to-back: frame sync on the last bit of 0xF0 chains into 0x0F.
    wr0 = wr_cnt;
    n0  = wr_dat.size();
    send_frame(8'hF0, -1, 1'b1, 1'b1);
    lf1 = last_fall;
    send_frame(8'h0F, -1, 1'b0, 1'b0);
    lf2 = last_fall;
    repeat (4 + XLAT) @(negedge pclk);
    chk("b2b_wr", 32'(wr_cnt - wr0), 32'd2);
    if (wr_dat.size() >= n0 + 2) begin
      chk("b2b_data0", 32'(wr_dat[n0]), 32'hF0);
      chk("b2b_data1", 32'(wr_dat[n0+1]), 32'h0F);
      chk("b2b_spacing", 32'(wr_cyc[n0+1] - wr_cyc[n0]), 32'(2 * W * HALF));
      chk("b2b_first_cyc", 32'(wr_cyc[n0]), 32'(lf1 + XLAT));
    end else begin
      chk("b2b_pulses_seen", 32'(wr_dat.size() - n0), 32'd2);
    end
    chk("b2b_fall_spacing", 32'(lf2 - lf1), 32'(2 * W * HALF));

    // Reset mid-frame after 4 bits of 0xFF: partial word dropped, fresh sync needed.
    wr0  = wr_cnt;
    ovr0 = ovr_cnt;
    sbit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) sbit(1'b0, 1'b1);
    wait_to(last_fall + XLAT);
    chk("midrst_busy_before", 32'(rx_busy), 32'd1);
    clear_b = 1'b0;
    #1;
    chk("midrst_busy_async", 32'(rx_busy), 32'd0);
    repeat (3) @(negedge pclk);
    clear_b = 1'b1;
    @(negedge pclk);
    send_frame(8'hFF, -1, 1'b0, 1'b0);
    repeat (4 + XLAT) @(negedge pclk);
    chk("midrst_nosync_wr", 32'(wr_cnt - wr0), 32'd0);
    send_frame(8'h81, -1, 1'b0, 1'b1);
    repeat (4 + XLAT) @(negedge pclk);
    chk("midrst_wr", 32'(wr_cnt - wr0), 32'd1);
    chk("midrst_ovr", 32'(ovr_cnt - ovr0), 32'd0);
    chk("midrst_data", 32'(rx_if.rx_wr_data), 32'h81);

    chk("wr_ovr_exclusive", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
